// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer writer.
// FB_WRITER_ALPHA_EN selects an opaque (8'hFF) alpha byte instead of 8'h00.
package fb_pkg;

    localparam int HDISP_DEF       = 800;
    localparam int VDISP_DEF       = 480;
    localparam int BYTES_PER_PIXEL = 4;

`ifdef FB_WRITER_ALPHA_EN
    localparam logic [7:0] ALPHA_BYTE = 8'hFF;
`else
    localparam logic [7:0] ALPHA_BYTE = 8'h00;
`endif

    typedef struct packed {
        logic        sof;
        logic [23:0] rgb;
    } fb_entry_t;

    typedef enum logic [0:0] {
        BUS_IDLE  = 1'b0,
        BUS_WRITE = 1'b1
    } bus_state_t;

    typedef enum logic [0:0] {
        IN_WAIT_SOF = 1'b0,
        IN_RUN      = 1'b1
    } in_state_t;

endpackage

// File: rtl/fb_writer_if.sv
// Write-only Wishbone master/slave bundle shared by the framebuffer writer and its bus.
interface wshb_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (output cyc, stb, we, sel, adr, dat_ms, cti, bte, input ack);
    modport slave  (input cyc, stb, we, sel, adr, dat_ms, cti, bte, output ack);

endinterface

// File: rtl/fb_writer_sync_fifo.sv
// Single-clock show-ahead FIFO: rdata always presents the head entry while not empty.
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr[PW-1:0]];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fb_writer.sv
// Wishbone master writing a raster pixel stream into a linear 32-bit framebuffer.
// Build macro FB_WRITER_ALPHA_EN sets dat_ms[31:24] to 8'hFF (otherwise 8'h00).
module fb_writer
    import fb_pkg::*;
#(
    parameter int HDISP      = HDISP_DEF,
    parameter int VDISP      = VDISP_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_sof,
    input  logic [23:0] pix_data,
    wshb_if.master      wshb_ifm,
    output logic        frame_done,
    output logic        sof_err
);

    localparam int FRAME_BYTES = BYTES_PER_PIXEL * HDISP * VDISP;
    localparam int AW          = $clog2(FRAME_BYTES);
    localparam int CW          = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADR = AW'(FRAME_BYTES - BYTES_PER_PIXEL);
    localparam logic [AW-1:0] ADR_STEP = AW'(BYTES_PER_PIXEL);
    localparam logic [CW-1:0] OCC_FULL = CW'(FIFO_DEPTH);

    in_state_t   r_in_state;
    in_state_t   w_in_next;
    bus_state_t  r_bus_state;
    bus_state_t  w_bus_next;
    fb_entry_t   w_wr_entry;
    fb_entry_t   w_head;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_load;
    logic        w_ack_done;
    logic [AW-1:0] w_load_adr;
    logic [AW-1:0] r_adr;
    logic [AW-1:0] r_next_adr;
    logic [CW-1:0] r_occ;
    logic [31:0] r_dat;
    logic        r_cyc;
    logic        r_stb;
    logic        r_frame_done;
    logic        r_sof_err;

    // The word on the bus is popped from the FIFO when loaded, so r_occ counts it
    // too: the block holds FIFO_DEPTH pixels in total, including the one in flight.
    sync_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_load),
        .wdata (w_wr_entry),
        .rdata (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_wr_entry = '{sof: pix_sof, rgb: pix_data};
    assign w_push     = pix_valid && pix_ready && ((r_in_state == IN_RUN) || pix_sof);
    assign w_ack_done = (r_bus_state == BUS_WRITE) && wshb_ifm.ack;
    assign w_load_adr = w_head.sof ? '0 : r_next_adr;

    // Input-side ready: WAIT_SOF swallows everything until a frame start arrives.
    always_comb begin
        pix_ready = 1'b0;
        if (rst) begin
            pix_ready = 1'b0;
        end else if (r_in_state == IN_WAIT_SOF) begin
            pix_ready = 1'b1;
        end else begin
            pix_ready = !(w_fifo_full || (r_occ == OCC_FULL));
        end
    end

    // Input FSM next state.
    always_comb begin
        w_in_next = r_in_state;
        case (r_in_state)
            IN_WAIT_SOF: begin
                if (w_push) begin
                    w_in_next = IN_RUN;
                end else begin
                    w_in_next = IN_WAIT_SOF;
                end
            end
            IN_RUN:  w_in_next = IN_RUN;
            default: w_in_next = IN_WAIT_SOF;
        endcase
    end

    // Bus FSM next state and head load.
    always_comb begin
        w_bus_next = r_bus_state;
        w_load     = 1'b0;
        case (r_bus_state)
            BUS_IDLE: begin
                if (!w_fifo_empty) begin
                    w_bus_next = BUS_WRITE;
                    w_load     = 1'b1;
                end else begin
                    w_bus_next = BUS_IDLE;
                end
            end
            BUS_WRITE: begin
                if (wshb_ifm.ack) begin
                    if (!w_fifo_empty) begin
                        w_bus_next = BUS_WRITE;
                        w_load     = 1'b1;
                    end else begin
                        w_bus_next = BUS_IDLE;
                    end
                end else begin
                    w_bus_next = BUS_WRITE;
                end
            end
            default: w_bus_next = BUS_IDLE;
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state  <= IN_WAIT_SOF;
            r_bus_state <= BUS_IDLE;
        end else begin
            r_in_state  <= w_in_next;
            r_bus_state <= w_bus_next;
        end
    end

    // Registered bus outputs, address counter, status pulses and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_adr        <= '0;
            r_next_adr   <= '0;
            r_dat        <= 32'h0000_0000;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
            r_occ        <= '0;
        end else begin
            r_cyc <= (w_bus_next == BUS_WRITE);
            r_stb <= (w_bus_next == BUS_WRITE);
            if (w_load) begin
                r_adr      <= w_load_adr;
                r_dat      <= {ALPHA_BYTE, w_head.rgb};
                r_next_adr <= (w_load_adr == LAST_ADR) ? '0 : (w_load_adr + ADR_STEP);
            end
            r_sof_err    <= w_load && w_head.sof && (r_next_adr != '0);
            r_frame_done <= w_ack_done && (r_adr == LAST_ADR);
            case ({w_push, w_ack_done})
                2'b10:   r_occ <= r_occ + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_occ <= r_occ - {{(CW-1){1'b0}}, 1'b1};
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign wshb_ifm.cyc    = r_cyc;
    assign wshb_ifm.stb    = r_stb;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.adr    = {{(32-AW){1'b0}}, r_adr};
    assign wshb_ifm.dat_ms = r_dat;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign frame_done      = r_frame_done;
    assign sof_err         = r_sof_err;

endmodule

// File: doc/fb_writer.md
# fb_writer

Wishbone master that writes a raster pixel stream into the linear 32-bit framebuffer scanned out by the display controller: word address = 4 × (line × HDISP + pixel), one pixel per word, RGB in bits 23:0. It sits between a same-clock pixel source (test-pattern or capture path) and the SDRAM-side Wishbone bus. A small show-ahead FIFO absorbs bus latency. Frame alignment comes from a start-of-frame flag carried with each pixel.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- FIFO_DEPTH, 16, entries in the internal FIFO (power of two, ≥ 2)
- clk  in  1  Wishbone clock; the whole block is in this domain (same net as wshb_ifm.clk)
- rst  in  1  reset, synchronous, active-high
- pix_valid  in  1  input pixel valid
- pix_ready  out  1  block accepts a pixel this cycle
- pix_sof  in  1  pixel is (line 0, pixel 0) of a frame
- pix_data  in  24  RGB, R in 23:16
- wshb_ifm  wshb_if.master  drives cyc, stb, we, sel, adr, dat_ms, cti, bte; samples ack
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is acknowledged
- sof_err  out  1  one-cycle pulse when pix_sof arrives mid-frame

## Operation
- Constants: we=1, sel=4'hF, cti=3'b000, bte=2'b00.
- Accept: a transfer happens when pix_valid && pix_ready. pix_ready = ~fifo_full, except in WAIT_SOF.
- Input FSM:
  - WAIT_SOF: pix_ready=1. Pixels with sof=0 are accepted and dropped. A sof=1 pixel is pushed to the FIFO and the FSM moves to RUN.
  - RUN: every accepted pixel is pushed. The FSM stays in RUN.
- FIFO entry is 25 bits: {sof, rgb}.
- Bus FSM:
  - IDLE: cyc=stb=0. When the FIFO is non-empty, go to WRITE at the next edge.
  - WRITE: cyc=stb=1. adr is the current address, with adr=0 substituted if the head entry has sof=1. dat_ms = {alpha, head rgb}.
  - On ack, pop the head. Next adr = current+4, or 0 after 4·HDISP·VDISP−4. Stay in WRITE if another entry is available, else go to IDLE.
- Address counter width: $clog2(4·HDISP·VDISP) bits, zero-extended to 32.
- Wrap: ack at adr 4·HDISP·VDISP−4 pulses frame_done in the following cycle; next adr is 0.
- sof at head while address ≠ 0: pulse sof_err, write that pixel at 0, and continue from 4.
- Simultaneous push and pop: both take effect; the FIFO count is unchanged.

## Timing
- Reset values: cyc=0, stb=0, adr=0, dat_ms=0, frame_done=0, sof_err=0. pix_ready=0 while rst is high.
- After reset: FIFO empty, input FSM in WAIT_SOF, bus FSM in IDLE.
- cyc, stb, adr and dat_ms are registered.
- Latency: a pixel accepted at edge N can appear as stb=1 with its data from cycle N+1 onward.
- stb/adr/dat_ms are held stable until the cycle ack=1.
- With ack constantly high, the bus sustains one write per cycle.
- Full: pix_ready falls in the same cycle the count reaches FIFO_DEPTH. No pixel is ever lost.
- rst mid-transaction: cyc/stb are 0 in the cycle after the rst edge, the FIFO is flushed, and the block re-enters WAIT_SOF. A late ack is ignored.

## Configuration
- FB_WRITER_ALPHA_EN
  - Defined: dat_ms[31:24]=8'hFF (opaque alpha for blending consumers).
  - Undefined: dat_ms[31:24]=8'h00.
  - No other behaviour changes.

## Structure
- Shared package `fb_pkg`: default HDISP/VDISP, the BYTES_PER_PIXEL=4 constant, the FIFO entry typedef {logic sof; logic [23:0] rgb}, and the bus FSM state enum.
- Sub-module `sync_fifo`:
  - Single-clock, show-ahead.
  - Ports: full, empty, push, pop, wdata, rdata.
  - Parameterised width/depth.
  - Reused elsewhere.

## Test plan
- Reset, 4 pixels 0x000001..0x000004 with sof on the first, ack tied high → writes at adr 0,4,8,12 with dat_ms 0x00000001..0x00000004 (0xFF000001.. with FB_WRITER_ALPHA_EN).
- ack held low 40 cycles while pix_valid is held high, FIFO_DEPTH=16 → exactly 16 pixels accepted, pix_ready=0 afterwards, all 16 written in order once ack resumes.
- HDISP=4, VDISP=2, two full frames → adr sequence 0..28 then 0..28, one frame_done pulse per ack at adr 28.
- 3 pixels with sof=0, then sof pixel 0xABCDEF → first bus write is adr 0, dat 0x00ABCDEF; the earlier pixels never reach the bus.
- sof asserted on the 6th pixel of a frame → sof_err pulses once, that pixel is written at adr 0, and the next pixel at adr 4.
- rst asserted while stb=1, ack=0 → cyc=stb=0 next cycle, adr=0, and the next write waits for a new sof.
